// File: rtl/spi_target_regfile_if.sv
// spi_target_regfile_if: SPI link between a register-file master and its target
// Signals: sclk (idle low), cs_n (active low), mosi, miso, miso_oe (target drives miso while selected)
// Modports: master drives sclk/cs_n/mosi; slave drives miso/miso_oe
interface spi_target_regfile_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;
    modport master (output sclk, cs_n, mosi, input miso, miso_oe);
    modport slave (input sclk, cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_target_regfile.sv
// spi_target_regfile: SPI mode-0 target decoding {rw,addr[6:0]} + W_DATA-bit word frames into a register bank
// Ports: clk, rst (async, active low), spi (slave modport: sclk/cs_n/mosi in, miso/miso_oe out),
//        host_ra/host_rd (combinational local read), frame_done/wr_strobe/frame_err (1-cycle pulses)
// Option: define SPI_TARGET_AUTOINC_EN to let extra sclk edges after a word continue a burst at addr+1
module spi_target_regfile #(
    parameter int W_DATA = 32,
    parameter int DEPTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_target_regfile_if.slave      spi,
    input  logic [$clog2(DEPTH)-1:0] host_ra,
    output logic [W_DATA-1:0]        host_rd,
    output logic                     frame_done,
    output logic                     wr_strobe,
    output logic                     frame_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(W_DATA) + 1;
    localparam logic [CW-1:0] LAST = CW'(W_DATA - 1);
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    state_t state, nxt;
    logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
    logic sclk_p, cs_p, sclk_q, cs_q, mosi_q, rise, fall, cs_fall;
    logic [W_DATA-1:0] bank [DEPTH];
    logic [W_DATA-1:0] rx, tx;
    logic [CW-1:0] cnt;
    logic [6:0] addr, cmd_addr;
    logic rw, fin, cmd_ok, addr_ok;
`ifdef SPI_TARGET_AUTOINC_EN
    logic [6:0] next_addr;
    assign next_addr = int'(addr) >= DEPTH - 1 ? 7'd0 : addr + 7'd1;
    assign spi.miso = (state == DATA || state == DONE) && tx[W_DATA-1];
`else
    assign spi.miso = state == DATA && tx[W_DATA-1];
`endif
    assign sclk_q = sclk_s[SYNC_STAGES-1];
    assign cs_q = cs_s[SYNC_STAGES-1];
    assign mosi_q = mosi_s[SYNC_STAGES-1];
    assign rise = sclk_q && !sclk_p;
    assign fall = !sclk_q && sclk_p;
    assign cs_fall = cs_p && !cs_q;
    assign cmd_addr = {rx[5:0], mosi_q};
    assign cmd_ok = int'(cmd_addr) < DEPTH;
    assign addr_ok = int'(addr) < DEPTH;
    assign host_rd = bank[host_ra];
    assign spi.miso_oe = state != IDLE;
    // cs_n synchroniser resets low so a select already active when reset releases is never seen as a fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s <= '0;
            cs_s <= '0;
            mosi_s <= '0;
            sclk_p <= 1'b0;
            cs_p <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi.sclk};
            cs_s <= {cs_s[SYNC_STAGES-2:0], spi.cs_n};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi.mosi};
            sclk_p <= sclk_q;
            cs_p <= cs_q;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = cs_fall ? CMD : IDLE;
            CMD: nxt = cs_q ? IDLE : (rise && cnt == CW'(7)) ? DATA : CMD;
            DATA: nxt = cs_q ? IDLE : (rise && cnt == LAST) ? DONE : DATA;
`ifdef SPI_TARGET_AUTOINC_EN
            DONE: nxt = cs_q ? IDLE : rise ? DATA : DONE;
`else
            DONE: nxt = cs_q ? IDLE : DONE;
`endif
        endcase
    end
    // fin marks a completed word; its commit and pulses land one clock after entering DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
            rx <= '0;
            tx <= '0;
            cnt <= '0;
            addr <= '0;
            rw <= 1'b0;
            fin <= 1'b0;
            frame_done <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            fin <= 1'b0;
            frame_done <= fin;
            wr_strobe <= fin && addr_ok && !rw;
            frame_err <= (fin && !addr_ok) || (cs_q && (state == CMD || state == DATA));
            if (fin && addr_ok && !rw) bank[addr[AW-1:0]] <= rx;
            case (state)
                IDLE: if (cs_fall) begin
                    cnt <= '0;
                    rx <= '0;
                end
                CMD: if (!cs_q && rise) begin
                    rx <= {rx[W_DATA-2:0], mosi_q};
                    cnt <= cnt == CW'(7) ? '0 : cnt + 1'b1;
                    if (cnt == CW'(7)) begin
                        rw <= rx[6];
                        addr <= cmd_addr;
                        tx <= rx[6] && cmd_ok ? bank[cmd_addr[AW-1:0]] : '0;
                    end
                end
                DATA: if (!cs_q) begin
                    if (rise) begin
                        rx <= {rx[W_DATA-2:0], mosi_q};
                        cnt <= cnt + 1'b1;
                        fin <= cnt == LAST;
`ifdef SPI_TARGET_AUTOINC_EN
                        if (cnt == LAST) tx <= rw ? bank[next_addr[AW-1:0]] : '0;
`endif
                    end
                    // the first fall after the command only exposes the preloaded MSB
                    if (fall && cnt != '0) tx <= tx << 1;
                end
`ifdef SPI_TARGET_AUTOINC_EN
                DONE: if (!cs_q && rise) begin
                    rx <= {rx[W_DATA-2:0], mosi_q};
                    cnt <= CW'(1);
                    addr <= next_addr;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_target_regfile.sv
// tb_spi_target_regfile: self-checking bench for spi_target_regfile (directed table, hand sequences, random vs model)
module tb_spi_target_regfile;
    localparam int H = 5;
    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        int          nb;
        logic [31:0] exp_miso;
        int          done;
        int          wr;
        int          err;
        int          ra;
        logic [31:0] exp_rd;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] host_ra;
    logic [31:0] host_rd;
    logic frame_done, wr_strobe, frame_err;
    int tests = 0, fails = 0;
    int n_done = 0, n_wr = 0, n_err = 0;
    logic [31:0] model [16];
    vec_t v [7];
    always #5 clk = ~clk;
    spi_target_regfile_if spi();
    spi_target_regfile dut (
        .clk(clk),
        .rst(rst),
        .spi(spi),
        .host_ra(host_ra),
        .host_rd(host_rd),
        .frame_done(frame_done),
        .wr_strobe(wr_strobe),
        .frame_err(frame_err)
    );
    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (wr_strobe) n_wr++;
        if (frame_err) n_err++;
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic peek(input int ra, output logic [31:0] val);
        host_ra = 4'(ra);
        #1;
        val = host_rd;
    endtask
    task automatic send_bit(input logic b, output logic m);
        spi.mosi = b;
        tick(H);
        m = spi.miso;
        spi.sclk = 1'b1;
        tick(H);
        spi.sclk = 1'b0;
    endtask
    task automatic frame(input logic [7:0] cmd, input logic [63:0] data, input int nb,
                         output logic [31:0] rd, output logic oe, output int dd, output int dw, output int de);
        logic [71:0] w;
        logic m;
        int d0, w0, e0;
        w = {cmd, data};
        rd = '0;
        oe = 1'b0;
        d0 = n_done;
        w0 = n_wr;
        e0 = n_err;
        spi.cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < nb; i++) begin
            send_bit(w[71-i], m);
            if (i >= 8) rd = {rd[30:0], m};
            if (i == 7) oe = spi.miso_oe;
        end
        tick(H);
        spi.mosi = 1'b0;
        spi.cs_n = 1'b1;
        tick(12);
        dd = n_done - d0;
        dw = n_wr - w0;
        de = n_err - e0;
    endtask
    initial begin
        logic [31:0] rd, val, acc;
        logic oe, m;
        int dd, dw, de, w0, e0;
        v[0] = '{8'h03, 32'hDEADBEEF, 40, 32'h0, 1, 1, 0, 3, 32'hDEADBEEF};
        v[1] = '{8'h83, 32'h0, 40, 32'hDEADBEEF, 1, 0, 0, 3, 32'hDEADBEEF};
        v[2] = '{8'h05, 32'hAAAA5555, 20, 32'h0, 0, 0, 1, 5, 32'h0};
        v[3] = '{8'h20, 32'h12345678, 40, 32'h0, 1, 0, 1, 0, 32'h0};
        v[4] = '{8'hA0, 32'h0, 40, 32'h0, 1, 0, 1, 3, 32'hDEADBEEF};
        v[5] = '{8'h07, 32'hFFFFFFFF, 5, 32'h0, 0, 0, 1, 7, 32'h0};
        v[6] = '{8'h87, 32'h0, 40, 32'h0, 1, 0, 0, 7, 32'h0};
        for (int i = 0; i < 16; i++) model[i] = '0;
        rst = 1'b0;
        spi.cs_n = 1'b1;
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        host_ra = '0;
        tick(5);
        check("reset_miso", 32'(spi.miso), 32'h0);
        check("reset_oe", 32'(spi.miso_oe), 32'h0);
        check("reset_pulses", 32'(n_done + n_wr + n_err), 32'h0);
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            peek(i, val);
            acc |= val;
        end
        check("reset_bank", acc, 32'h0);
        rst = 1'b1;
        tick(5);
        for (int i = 0; i < 7; i++) begin
            frame(v[i].cmd, {v[i].data, 32'h0}, v[i].nb, rd, oe, dd, dw, de);
            if (v[i].nb == 40) check($sformatf("v%0d_miso", i), rd, v[i].exp_miso);
            if (v[i].nb >= 8) check($sformatf("v%0d_oe", i), 32'(oe), 32'h1);
            check($sformatf("v%0d_oe_idle", i), 32'({spi.miso_oe, spi.miso}), 32'h0);
            check($sformatf("v%0d_done", i), 32'(dd), 32'(v[i].done));
            check($sformatf("v%0d_wr", i), 32'(dw), 32'(v[i].wr));
            check($sformatf("v%0d_err", i), 32'(de), 32'(v[i].err));
            peek(v[i].ra, val);
            check($sformatf("v%0d_bank", i), val, v[i].exp_rd);
        end
        model[3] = 32'hDEADBEEF;
        // reset asserted in the middle of a write's data phase
        w0 = n_wr;
        e0 = n_err;
        spi.cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < 18; i++) send_bit(i == 7 ? 1'b1 : (i >= 8 ? 1'b1 : 1'b0), m);
        rst = 1'b0;
        tick(2);
        check("rst_mid_oe", 32'(spi.miso_oe), 32'h0);
        check("rst_mid_miso", 32'(spi.miso), 32'h0);
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            peek(i, val);
            acc |= val;
        end
        check("rst_mid_bank", acc, 32'h0);
        rst = 1'b1;
        tick(2);
        for (int i = 0; i < 22; i++) send_bit(1'b1, m);
        tick(H);
        spi.mosi = 1'b0;
        spi.cs_n = 1'b1;
        tick(12);
        check("rst_tail_wr", 32'(n_wr - w0), 32'h0);
        check("rst_tail_err", 32'(n_err - e0), 32'h0);
        peek(1, val);
        check("rst_tail_bank1", val, 32'h0);
        for (int i = 0; i < 16; i++) model[i] = '0;
        frame(8'h01, {32'hCAFEF00D, 32'h0}, 40, rd, oe, dd, dw, de);
        model[1] = 32'hCAFEF00D;
        check("post_rst_wr", 32'(dw), 32'h1);
        peek(1, val);
        check("post_rst_bank1", val, 32'hCAFEF00D);
        // two words in one frame to addr 15: a burst wraps to 0, a single-word target ignores the rest
        frame(8'h0F, {32'h1, 32'h2}, 72, rd, oe, dd, dw, de);
        model[15] = 32'h1;
`ifdef SPI_TARGET_AUTOINC_EN
        model[0] = 32'h2;
        check("burst_wr", 32'(dw), 32'h2);
        check("burst_done", 32'(dd), 32'h2);
`else
        check("burst_wr", 32'(dw), 32'h1);
        check("burst_done", 32'(dd), 32'h1);
`endif
        check("burst_err", 32'(de), 32'h0);
        peek(15, val);
        check("burst_bank15", val, model[15]);
        peek(0, val);
        check("burst_bank0", val, model[0]);
        for (int k = 0; k < 40; k++) begin
            logic rw, full, ok;
            logic [6:0] a;
            logic [31:0] d, exp_rd;
            int nb;
            rw = 1'($urandom_range(0, 1));
            a = 7'($urandom_range(0, 19));
            d = $urandom;
            nb = $urandom_range(0, 4) == 0 ? $urandom_range(1, 39) : 40;
            full = nb == 40;
            ok = a < 7'd16;
            exp_rd = ok ? model[a[3:0]] : 32'h0;
            frame({rw, a}, {d, 32'h0}, nb, rd, oe, dd, dw, de);
            if (full && !rw && ok) model[a[3:0]] = d;
            if (full && rw) check($sformatf("rnd%0d_miso", k), rd, exp_rd);
            check($sformatf("rnd%0d_done", k), 32'(dd), 32'(full));
            check($sformatf("rnd%0d_wr", k), 32'(dw), 32'(full && !rw && ok));
            check($sformatf("rnd%0d_err", k), 32'(de), 32'(!full || !ok));
            peek(int'(a[3:0]), val);
            check($sformatf("rnd%0d_bank", k), val, model[a[3:0]]);
        end
        for (int i = 0; i < 16; i++) begin
            peek(i, val);
            check($sformatf("final_bank%0d", i), val, model[i]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
